// File: rtl/fadd_arbiter.sv
// fadd_arbiter: round-robin sharing of one combinational single-precision adder between two valid/ready ports
//   clk, rst       : clock, synchronous active-high reset
//   req_*_k        : request channel k (valid/ready, operands x1/x2, sub inverts sign of x2)
//   rsp_*_k        : response channel k (valid/ready, sum y, overflow ovf), held until taken
//   ops_done       : number of results written into the response registers, wrapping
module fadd (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        ovf
);
  logic swap, sa, sb, rup, nan;
  logic [31:0] la, lb;
  logic [7:0] ea, eb, d;
  logic [23:0] ma, mb;
  logic [55:0] t;
  logic [27:0] xa, xb, s;
  logic [26:0] n;
  logic [4:0] lz;
  logic [24:0] m;
  logic signed [9:0] e0, e;
  always_comb begin
    swap = b[30:0] > a[30:0];
    la = swap ? b : a;
    lb = swap ? a : b;
    {sa, ea} = {la[31], la[30:23]};
    {sb, eb} = {lb[31], lb[30:23]};
    // denormal operands are flushed to zero
    ma = ea != 8'd0 ? {1'b1, la[22:0]} : 24'd0;
    mb = eb != 8'd0 ? {1'b1, lb[22:0]} : 24'd0;
    d = ea - eb;
    t = {1'b0, mb, 3'b0, 28'b0} >> (d > 8'd31 ? 8'd31 : d);
    xa = {1'b0, ma, 3'b0};
    // bits shifted past the guard positions collapse into a sticky lsb
    xb = {t[55:29], t[28] | (|t[27:0])};
    s = sa ^ sb ? xa - xb : xa + xb;
    lz = '0;
    for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
    n = s[27] ? {s[27:2], s[1] | s[0]} : s[26:0] << lz;
    e0 = s[27] ? $signed({2'b0, ea}) + 10'sd1 : $signed({2'b0, ea}) - $signed({5'b0, lz});
    rup = n[2] && (n[1] || n[0] || n[3]);
    m = {1'b0, n[26:3]} + 25'(rup);
    e = e0 + (m[24] ? 10'sd1 : 10'sd0);
    y = {sa, e[7:0], m[24] ? m[23:1] : m[22:0]};
    ovf = 1'b0;
    if (s == '0) y = {sa & sb, 31'b0};
    else if (e >= 10'sd255) begin
      y = {sa, 8'hFF, 23'b0};
      ovf = 1'b1;
    end else if (e <= 10'sd0) y = {sa, 31'b0};
    nan = (ea == 8'hFF && la[22:0] != 23'd0) || (eb == 8'hFF && lb[22:0] != 23'd0) ||
          (ea == 8'hFF && eb == 8'hFF && sa != sb);
    if (ea == 8'hFF || eb == 8'hFF) begin
      ovf = 1'b0;
      y = nan ? 32'h7FC00000 : {sa, 8'hFF, 23'b0};
    end
  end
endmodule

module fadd_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [31:0]      req_x1_0,
  input  logic [31:0]      req_x2_0,
  input  logic             req_sub_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [31:0]      req_x1_1,
  input  logic [31:0]      req_x2_1,
  input  logic             req_sub_1,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic [31:0]      rsp_y_0,
  output logic             rsp_ovf_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [31:0]      rsp_y_1,
  output logic             rsp_ovf_1,
  output logic [CNT_W-1:0] ops_done
);
  logic opv, op_id, rr_ptr, ovf, slot_ok_0, slot_ok_1, acc_0, acc_1;
  logic [31:0] op_x1, op_x2, y;
  fadd u_fadd (.a(op_x1), .b(op_x2), .y(y), .ovf(ovf));
  // a port may issue only if its response register will be free when the result lands
  assign slot_ok_0 = !(opv && !op_id) && (!rsp_valid_0 || rsp_ready_0);
  assign slot_ok_1 = !(opv && op_id) && (!rsp_valid_1 || rsp_ready_1);
  assign req_ready_0 = slot_ok_0 && (!(req_valid_1 && slot_ok_1) || !rr_ptr);
  assign req_ready_1 = slot_ok_1 && (!(req_valid_0 && slot_ok_0) || rr_ptr);
  assign acc_0 = req_valid_0 && req_ready_0;
  assign acc_1 = req_valid_1 && req_ready_1;
  always_ff @(posedge clk) begin
    if (rst) begin
      opv <= 1'b0;
      op_id <= 1'b0;
      rr_ptr <= 1'b0;
      op_x1 <= '0;
      op_x2 <= '0;
      rsp_valid_0 <= 1'b0;
      rsp_y_0 <= '0;
      rsp_ovf_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_y_1 <= '0;
      rsp_ovf_1 <= 1'b0;
      ops_done <= '0;
    end else begin
      opv <= acc_0 || acc_1;
      if (acc_0 || acc_1) begin
        op_id <= acc_1;
        op_x1 <= acc_1 ? req_x1_1 : req_x1_0;
        op_x2 <= acc_1 ? {req_x2_1[31] ^ req_sub_1, req_x2_1[30:0]} : {req_x2_0[31] ^ req_sub_0, req_x2_0[30:0]};
        rr_ptr <= !acc_1;
      end
      // a completing result takes precedence over a pop in the same cycle
      if (opv && !op_id) begin
        rsp_valid_0 <= 1'b1;
        rsp_y_0 <= y;
        rsp_ovf_0 <= ovf;
      end else if (rsp_ready_0) rsp_valid_0 <= 1'b0;
      if (opv && op_id) begin
        rsp_valid_1 <= 1'b1;
        rsp_y_1 <= y;
        rsp_ovf_1 <= ovf;
      end else if (rsp_ready_1) rsp_valid_1 <= 1'b0;
      ops_done <= ops_done + CNT_W'(opv);
    end
  end
endmodule

// File: tb/tb_fadd_arbiter.sv
// tb_fadd_arbiter: scoreboard bench for fadd_arbiter with directed vectors
module tb_fadd_arbiter;
  logic clk, rst;
  logic req_valid_0, req_ready_0, req_sub_0, req_valid_1, req_ready_1, req_sub_1;
  logic [31:0] req_x1_0, req_x2_0, req_x1_1, req_x2_1;
  logic rsp_valid_0, rsp_ready_0, rsp_ovf_0, rsp_valid_1, rsp_ready_1, rsp_ovf_1;
  logic [31:0] rsp_y_0, rsp_y_1;
  logic [15:0] ops_done;
  logic [32:0] q0[$], q1[$];
  int tests = 0, fails = 0;
  logic [31:0] vx1[8], vx2[8];
  logic vsub[8];
  logic [32:0] vexp[8];

  fadd_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_x1_0(req_x1_0), .req_x2_0(req_x2_0), .req_sub_0(req_sub_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_x1_1(req_x1_1), .req_x2_1(req_x2_1), .req_sub_1(req_sub_1),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0), .rsp_y_0(rsp_y_0), .rsp_ovf_0(rsp_ovf_0),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1), .rsp_y_1(rsp_y_1), .rsp_ovf_1(rsp_ovf_1),
    .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid_0 && rsp_ready_0) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp0_unexpected: got %h expected none", rsp_y_0);
      end else begin
        logic [32:0] e;
        e = q0.pop_front();
        check("rsp0_y", rsp_y_0, e[31:0]);
        check("rsp0_ovf", 32'(rsp_ovf_0), 32'(e[32]));
      end
    end
    if (!rst && rsp_valid_1 && rsp_ready_1) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp1_unexpected: got %h expected none", rsp_y_1);
      end else begin
        logic [32:0] e;
        e = q1.pop_front();
        check("rsp1_y", rsp_y_1, e[31:0]);
        check("rsp1_ovf", 32'(rsp_ovf_1), 32'(e[32]));
      end
    end
  end

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic drive(input bit p, input logic [31:0] a, input logic [31:0] b, input logic s);
    if (!p) {req_valid_0, req_x1_0, req_x2_0, req_sub_0} = {1'b1, a, b, s};
    else {req_valid_1, req_x1_1, req_x2_1, req_sub_1} = {1'b1, a, b, s};
  endtask

  task automatic send(input bit p, input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [32:0] e, input bit keep);
    int n;
    n = 0;
    drive(p, a, b, s);
    @(negedge clk);
    while (!(p ? req_ready_1 : req_ready_0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 20), 32'd1);
    if (keep) begin
      if (!p) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk); #1;
    if (!p) req_valid_0 = 1'b0;
    else req_valid_1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, i1;
    vx1 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000,
            32'h40800000, 32'h3F800000, 32'hBF800000, 32'h3F000000};
    vx2 = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F000000,
            32'h3F000000, 32'h40000000, 32'hBF800000, 32'h3E800000};
    vsub = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vexp = '{{1'b0, 32'h40000000}, {1'b0, 32'h40800000}, {1'b0, 32'h40000000}, {1'b0, 32'h3FC00000},
             {1'b0, 32'h40600000}, {1'b0, 32'hBF800000}, {1'b0, 32'hC0000000}, {1'b0, 32'h3F400000}};
    rst = 1'b1;
    {req_valid_0, req_x1_0, req_x2_0, req_sub_0} = '0;
    {req_valid_1, req_x1_1, req_x2_1, req_sub_1} = '0;
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b1;
    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid_0", 32'(rsp_valid_0), 32'd0);
    check("rst_rsp_valid_1", 32'(rsp_valid_1), 32'd0);
    check("rst_rsp_y_0", rsp_y_0, 32'd0);
    check("rst_ops_done", 32'(ops_done), 32'd0);
    check("rst_req_ready_0", 32'(req_ready_0), 32'd1);
    check("rst_req_ready_1", 32'(req_ready_1), 32'd1);
    @(posedge clk); #1;
    send(0, 32'h3F800000, 32'h40000000, 1'b0, {1'b0, 32'h40400000}, 1);
    @(negedge clk);
    check("lat_n1_valid_0", 32'(rsp_valid_0), 32'd0);
    @(negedge clk);
    check("lat_n2_valid_0", 32'(rsp_valid_0), 32'd1);
    check("lat_ops_done", 32'(ops_done), 32'd1);
    @(posedge clk); #1;
    send(1, 32'h3F800000, 32'h3F800000, 1'b1, {1'b0, 32'h00000000}, 1);
    send(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {1'b1, 32'h7F800000}, 1);
    cycles(3);

    do_reset();
    i0 = 0;
    i1 = 0;
    drive(0, vx1[0], vx2[0], vsub[0]);
    drive(1, vx1[4], vx2[4], vsub[4]);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("grant0", 32'(req_ready_0), 32'(c % 2 == 0));
      check("grant1", 32'(req_ready_1), 32'(c % 2 == 1));
      if (req_ready_0) begin
        q0.push_back(vexp[i0]);
        i0++;
      end else if (req_ready_1) begin
        q1.push_back(vexp[4 + i1]);
        i1++;
      end
      @(posedge clk); #1;
      if (i0 < 4) drive(0, vx1[i0], vx2[i0], vsub[i0]);
      else req_valid_0 = 1'b0;
      if (i1 < 4) drive(1, vx1[4 + i1], vx2[4 + i1], vsub[4 + i1]);
      else req_valid_1 = 1'b0;
    end
    cycles(4);

    rsp_ready_0 = 1'b0;
    send(0, 32'h3F800000, 32'h40000000, 1'b0, {1'b0, 32'h40400000}, 1);
    drive(0, 32'h40000000, 32'h40000000, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_req_ready_0", 32'(req_ready_0), 32'd0);
      if (c > 0) check("bp_rsp_y_0", rsp_y_0, 32'h40400000);
    end
    @(posedge clk); #1;
    send(1, 32'h40400000, 32'h3F800000, 1'b1, {1'b0, 32'h40000000}, 1);
    cycles(3);
    @(negedge clk);
    check("bp_hold_valid_0", 32'(rsp_valid_0), 32'd1);
    check("bp_hold_y_0", rsp_y_0, 32'h40400000);
    @(posedge clk); #1 rsp_ready_0 = 1'b1;
    @(negedge clk);
    check("bp_release_ready_0", 32'(req_ready_0), 32'd1);
    if (req_ready_0) q0.push_back({1'b0, 32'h40800000});
    @(posedge clk); #1;
    rsp_ready_0 = 1'b0;
    req_valid_0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_new_valid_0", 32'(rsp_valid_0), 32'd1);
    check("bp_new_y_0", rsp_y_0, 32'h40800000);
    @(posedge clk); #1 rsp_ready_0 = 1'b1;
    cycles(3);

    send(0, 32'h3F800000, 32'h3F800000, 1'b0, 33'd0, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rstfly_valid_0", 32'(rsp_valid_0), 32'd0);
      check("rstfly_ops_done", 32'(ops_done), 32'd0);
    end
    @(posedge clk); #1;
    drive(0, 32'h3F000000, 32'h3E800000, 1'b0);
    drive(1, 32'h40000000, 32'h40000000, 1'b0);
    @(negedge clk);
    check("rstfly_grant0", 32'(req_ready_0), 32'd1);
    check("rstfly_grant1", 32'(req_ready_1), 32'd0);
    if (req_ready_0) q0.push_back({1'b0, 32'h3F400000});
    @(posedge clk); #1;
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    cycles(5);
    @(negedge clk);
    check("end_q0_empty", 32'(q0.size()), 32'd0);
    check("end_q1_empty", 32'(q1.size()), 32'd0);
    check("end_ops_done", 32'(ops_done), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fadd_arbiter.md
# fadd_arbiter

Shares one combinational single-precision `fadd` instance between two requester ports (0 and 1) using round-robin arbitration. Each port has a valid/ready request channel carrying two IEEE-754 operands and a subtract flag, and a valid/ready response channel returning the sum and overflow flag. The block contains an operand pipeline register feeding `fadd`, plus one response holding register per port. It sits between the FPU issue logic and the shared adder.

## Interface
- CNT_W, 16, width of the completed-operation counter.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_0 / req_valid_1  in  1  request present on port k
- req_ready_0 / req_ready_1  out  1  request accepted this cycle when high together with req_valid_k
- req_x1_0 / req_x1_1  in  32  first operand
- req_x2_0 / req_x2_1  in  32  second operand
- req_sub_0 / req_sub_1  in  1  1: compute x1 - x2 by inverting bit 31 of x2 before latching
- rsp_valid_0 / rsp_valid_1  out  1  result held for port k
- rsp_ready_0 / rsp_ready_1  in  1  consumer takes result
- rsp_y_0 / rsp_y_1  out  32  `fadd` y for port k's operation
- rsp_ovf_0 / rsp_ovf_1  out  1  `fadd` ovf for port k's operation
- ops_done  out  CNT_W  count of results written into response registers; wraps modulo 2^CNT_W

## Operation
- State:
  - operand register: opv, op_id, op_x1, op_x2
  - response registers: rsp_valid_k, rsp_y_k, rsp_ovf_k
  - rr_ptr: 1 bit, identifies the port with priority
  - ops_done
- The single `fadd` instance is driven only by op_x1 and op_x2.
- slot_ok_k = !(opv && op_id==k) && (!rsp_valid_k || rsp_ready_k).
  - This guarantees that port k's response register is free when its operation completes.
- Ready logic (combinational; may depend on the other port's valid):
  - req_ready_k = slot_ok_k && (!(req_valid_j && slot_ok_j) || rr_ptr==k), where j is the other port.
  - The two readies are never both high while both valids are high.
- Accept on port k (req_valid_k && req_ready_k):
  - opv<=1, op_id<=k, op_x1<=req_x1_k.
  - op_x2<=req_x2_k with bit 31 XORed with req_sub_k.
  - rr_ptr<=j.
- No accept: opv<=0 and rr_ptr holds.
- When opv: rsp_valid_{op_id}<=1, rsp_y/ovf_{op_id} <= `fadd` y/ovf, ops_done<=ops_done+1.
- Response handshake: rsp_valid_k && rsp_ready_k clears rsp_valid_k.
  - If the same edge also writes a new port-k result, the write wins and rsp_valid_k stays 1.
  - slot_ok_k permits this write only when rsp_ready_k was high.
- rsp_y_k and rsp_ovf_k are stable while rsp_valid_k && !rsp_ready_k.
- NaN, Inf and denormal handling is entirely `fadd`'s. The block never alters results.

## Timing
- Reset (rst sampled high at an edge):
  - opv=0, rr_ptr=0, ops_done=0.
  - All rsp_valid_k=0, rsp_y_k=0, rsp_ovf_k=0.
  - req_ready_k follows the combinational equation, so both ports are ready after reset.
  - An operation in flight during reset is discarded and produces no response.
- Latency: accept in cycle n → rsp_valid_k high in cycle n+2.
- Throughput:
  - Combined, one accept per cycle (ports alternate under contention).
  - Single port, at most one accept every 2 cycles (slot_ok blocks while its own operation is in flight).
- Contention: with both valid and both slots OK, grant goes to rr_ptr, then priority flips.
  - A lone valid port with slot_ok is granted regardless of rr_ptr, and rr_ptr flips away from it.
- Backpressure: while rsp_ready_k is low and rsp_valid_k is high, req_ready_k stays 0. The other port is unaffected.
- ops_done increments exactly once per result write, including writes in the same cycle as a response pop.

## Test plan
- Reset, then port 0 sends 0x3F800000 + 0x40000000 with sub=0 and rsp_ready_0=1 → rsp_valid_0 two cycles after accept, rsp_y_0=0x40400000, rsp_ovf_0=0, ops_done=1.
- Port 1 sends 0x3F800000 and 0x3F800000 with sub=1 → rsp_y_1=0x00000000, rsp_ovf_1=0.
- Both ports valid continuously from reset, both rsp_ready high → grants 0,1,0,1 on consecutive cycles. Each port yields one result every 2 cycles, and each result has the correct port routing.
- Port 0 sends 0x7F7FFFFF + 0x7F7FFFFF → rsp_ovf_0=1, rsp_y_0=0x7F800000.
- rsp_ready_0 held low with result pending → req_ready_0=0 and rsp_y_0 stable. Port 1 still completes. Raising rsp_ready_0 for one cycle → req_ready_0 high that cycle.
- Assert rst the cycle after an accept → no rsp_valid appears, ops_done=0, rr_ptr=0 (port 0 wins the next contention).
